// File: rtl/rpt_event_log.sv
// rpt_event_log: saturating per-type event counters, timestamped severity-filtered log FIFO, and STOP/EXIT halt FSM.
module rpt_event_log #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             evt_valid_i,
    input  logic [1:0]       evt_type_i,
    input  logic [1:0]       evt_sev_i,
    input  logic [1:0]       evt_act_i,
    input  logic [7:0]       evt_src_i,
    input  logic [1:0]       thr_i,
    input  logic             clr_i,
    input  logic             resume_i,
    input  logic [1:0]       cnt_sel_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [7:0]       drop_cnt_o,
    output logic             log_valid_o,
    output logic [TS_W+11:0] log_data_o,
    input  logic             log_pop_i,
    output logic             stop_o,
    output logic             exit_o
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {RUN, STOPPED, EXITED} state_t;
    state_t state, state_nxt;
    logic [TS_W-1:0]  ts;
    logic [CNT_W-1:0] cnt [4];
    logic [7:0]       drop_cnt;
    logic [TS_W+11:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic accepted, logged, is_stop, is_exit, empty, full, pop, push, drop;
    always_comb begin
        accepted = evt_valid_i && state != EXITED && !clr_i;
        logged   = accepted && (evt_sev_i > thr_i);
        is_stop  = logged && evt_act_i == 2'd1;
        is_exit  = logged && evt_act_i == 2'd2;
        empty    = wr_ptr == rd_ptr;
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop      = log_pop_i && !empty && !clr_i;
        push     = logged && (!full || pop);
        drop     = logged && full && !pop;
    end
    // A clear freezes the state; a STOP racing a resume keeps the block stopped.
    always_comb begin
        state_nxt = state;
        if (!clr_i)
            case (state)
                RUN:     state_nxt = is_exit ? EXITED : is_stop ? STOPPED : RUN;
                STOPPED: state_nxt = is_exit ? EXITED : is_stop ? STOPPED : resume_i ? RUN : STOPPED;
                default: state_nxt = EXITED;
            endcase
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= RUN;
            ts       <= '0;
            drop_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_nxt;
            ts    <= ts + 1'b1;
            if (clr_i) begin
                drop_cnt <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                for (int i = 0; i < 4; i++) cnt[i] <= '0;
            end else begin
                if (accepted && cnt[evt_type_i] != '1) cnt[evt_type_i] <= cnt[evt_type_i] + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (push) begin
                    mem[wr_ptr[AW-1:0]] <= {ts, evt_src_i, evt_type_i, evt_sev_i};
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end
    assign cnt_o       = cnt[cnt_sel_i];
    assign drop_cnt_o  = drop_cnt;
    assign log_valid_o = !empty;
    assign log_data_o  = mem[rd_ptr[AW-1:0]];
    assign stop_o      = state == STOPPED;
    assign exit_o      = state == EXITED;
endmodule
